// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared types and frame-geometry helpers for the PPM receiver
package ppm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } rx_state_t;

  function automatic int frame_len(input int n, input int l);
    return (1 << n) * l;
  endfunction

  function automatic int tick_width(input int n, input int l);
    return (frame_len(n, l) > 1) ? $clog2(frame_len(n, l)) : 1;
  endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - enabled up-counter wrapping from MAX back to zero
module counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TOP) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_qualifier.sv
// rtl/pulse_qualifier.sv - synchronises the raw pulse and emits one edge per qualified high run
module pulse_qualifier #(
  parameter int MIN_W = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic qual_edge
);

  localparam int CW = $clog2(MIN_W + 1);
  localparam logic [CW-1:0] RUN_FIRE = CW'(MIN_W - 1);
  localparam logic [CW-1:0] RUN_SAT  = CW'(MIN_W);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run;

  // run saturates above the firing value, so a long pulse fires once and re-arms only on low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      run   <= '0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      if (!sync2) begin
        run <= '0;
      end else if (run != RUN_SAT) begin
        run <= run + 1'b1;
      end
    end
  end

  assign qual_edge = sync2 && (run == RUN_FIRE);

endmodule

// File: rtl/register.sv
// rtl/register.sv - enabled storage register cleared by reset
module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ppm_demodulator.sv
// rtl/ppm_demodulator.sv - locks to a preamble pulse and decodes one PPM symbol per frame
module ppm_demodulator
  import ppm_pkg::*;
#(
  parameter int N          = 2,
  parameter int L          = 4,
  parameter int MIN_W      = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_in,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         err,
  output logic         locked
);

  localparam int F  = frame_len(N, L);
  localparam int TW = tick_width(N, L);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(F - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  rx_state_t     state, state_nx;
  logic          qual_edge;
  logic          blind, blind_nx;
  logic          pre, pre_nx;
  logic [TW-1:0] tick;
  logic [N-1:0]  slot, slot_q, slot_nx, slot_eff;
  logic [1:0]    ecnt, ecnt_nx, ecnt_eff;
  logic [MW-1:0] miss, miss_nx;
  logic          tick_en, hunt_edge, count_edge, frame_end, decide;
  logic          valid_nx, err_nx;

  pulse_qualifier #(.MIN_W(MIN_W)) u_qual (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .qual_edge(qual_edge)
  );

  // in HUNT the counter sits at 0, so the preamble cycle is tick 0 and advancing it aligns the frame
  counter #(.W(TW), .MAX(F - 1)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .count(tick)
  );

  if ((L & (L - 1)) == 0) begin : g_slot_bits
    assign slot = tick[TW-1 -: N];
  end else begin : g_slot_cnt
    localparam int PW = $clog2(L);
    logic [PW-1:0] phase;

    counter #(.W(PW), .MAX(L - 1)) u_phase (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (tick_en),
      .count(phase)
    );

    counter #(.W(N), .MAX((1 << N) - 1)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (tick_en && (phase == PW'(L - 1))),
      .count(slot)
    );
  end

  always_comb begin
    hunt_edge  = (state == HUNT) && qual_edge && !blind;
    tick_en    = (state == LOCK) || hunt_edge;
    frame_end  = (state == LOCK) && (tick == LAST_TICK);
    count_edge = (state == LOCK) && !pre && qual_edge;
    decide     = frame_end && !pre;

    // fold an edge on the final tick into the frame it closes
    ecnt_eff = ecnt;
    slot_eff = slot_q;
    if (count_edge) begin
      slot_eff = (ecnt == 2'd0) ? slot : slot_q;
      ecnt_eff = (ecnt == 2'd0) ? 2'd1 : 2'd2;
    end

    valid_nx = decide && (ecnt_eff == 2'd1);
    err_nx   = decide && (ecnt_eff == 2'd2);
    ecnt_nx  = frame_end ? 2'd0 : ecnt_eff;
    slot_nx  = slot_eff;

    state_nx = state;
    pre_nx   = pre;
    blind_nx = 1'b0;
    miss_nx  = miss;

    case (state)
      HUNT: begin
        if (hunt_edge) begin
          state_nx = LOCK;
          pre_nx   = 1'b1;
        end
      end
      LOCK: begin
        if (frame_end) begin
          pre_nx = 1'b0;
        end
        if (decide) begin
          if (ecnt_eff != 2'd0) begin
            miss_nx = '0;
          end else if (miss == MISS_LAST) begin
            miss_nx  = '0;
            state_nx = HUNT;
            blind_nx = 1'b1;
          end else begin
            miss_nx = miss + 1'b1;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      blind  <= 1'b0;
      pre    <= 1'b0;
      ecnt   <= 2'd0;
      miss   <= '0;
      slot_q <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      blind  <= blind_nx;
      pre    <= pre_nx;
      ecnt   <= ecnt_nx;
      miss   <= miss_nx;
      slot_q <= slot_nx;
      valid  <= valid_nx;
      err    <= err_nx;
    end
  end

  register #(.W(N)) u_data (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (valid_nx),
    .d    (slot_eff),
    .q    (data)
  );

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_ppm_demodulator.sv
// tb/tb_ppm_demodulator.sv - directed bench with a frame-arithmetic reference model
module tb_ppm_demodulator;

  localparam int N  = 2;
  localparam int L  = 4;
  localparam int F  = 16;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic [1:0] d1_data, d2_data;
  logic       d1_valid, d1_err, d1_locked;
  logic       d2_valid, d2_err, d2_locked;

  ppm_demodulator #(.N(N), .L(L), .MIN_W(1), .MISS_LIMIT(ML)) dut1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in),
    .data(d1_data), .valid(d1_valid), .err(d1_err), .locked(d1_locked)
  );

  ppm_demodulator #(.N(N), .L(L), .MIN_W(2), .MISS_LIMIT(ML)) dut2 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in),
    .data(d2_data), .valid(d2_valid), .err(d2_err), .locked(d2_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // reference model: cycle-number arithmetic on frame positions relative to the preamble
  bit raw [0:8191];
  int hist_start = 0;
  bit in_reset = 1'b1;
  int mw       [2] = '{1, 2};
  bit m_lock   [2];
  int m_t0     [2];
  int m_listen [2];
  int m_miss   [2];
  int fr_cnt   [2];
  int fr_slot  [2];
  int ex_v     [2];
  int ex_e     [2];
  int ex_l     [2];
  int ex_d     [2];

  function automatic bit s2_at(input int c);
    int x;
    x = c - 2;
    return (x >= hist_start) ? raw[x] : 1'b0;
  endfunction

  function automatic bit qual(input int c, input int w);
    for (int i = 0; i < w; i++) if (!s2_at(c - i)) return 1'b0;
    return !s2_at(c - w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lock[i] = 0; m_t0[i] = 0; m_listen[i] = 0; m_miss[i] = 0;
      fr_cnt[i] = 0; fr_slot[i] = 0;
      ex_v[i] = 0; ex_e[i] = 0; ex_l[i] = 0; ex_d[i] = 0;
    end
  endtask

  task automatic step(input int i, input int c);
    bit e;
    int d, k, j, nv, ne;
    e  = qual(c, mw[i]);
    nv = 0;
    ne = 0;
    if (!m_lock[i]) begin
      if (e && c >= m_listen[i]) begin
        m_lock[i] = 1; m_t0[i] = c; fr_cnt[i] = 0;
      end
    end else begin
      d = c - m_t0[i];
      k = d / F;
      j = d % F;
      if (k >= 1) begin
        if (e) begin
          if (fr_cnt[i] == 0) fr_slot[i] = j / L;
          fr_cnt[i]++;
        end
        if (j == F - 1) begin
          if (fr_cnt[i] == 1) begin nv = 1; ex_d[i] = fr_slot[i]; end
          else if (fr_cnt[i] >= 2) ne = 1;
          if (fr_cnt[i] == 0) m_miss[i]++; else m_miss[i] = 0;
          if (m_miss[i] == ML) begin
            m_lock[i] = 0; m_miss[i] = 0; m_listen[i] = c + 2;
          end
          fr_cnt[i] = 0;
        end
      end
    end
    ex_v[i] = nv;
    ex_e[i] = ne;
    ex_l[i] = m_lock[i];
  endtask

  always @(negedge clk) begin
    raw[cyc] = pulse_in;
    if (!rst_n) begin
      model_reset();
      in_reset = 1'b1;
    end
    chk("d1.valid",  d1_valid,  ex_v[0]);
    chk("d1.err",    d1_err,    ex_e[0]);
    chk("d1.locked", d1_locked, ex_l[0]);
    chk("d1.data",   d1_data,   ex_d[0]);
    chk("d2.valid",  d2_valid,  ex_v[1]);
    chk("d2.err",    d2_err,    ex_e[1]);
    chk("d2.locked", d2_locked, ex_l[1]);
    chk("d2.data",   d2_data,   ex_d[1]);
    if (rst_n) begin
      if (in_reset) begin
        hist_start = cyc;
        in_reset   = 1'b0;
      end
      step(0, cyc);
      step(1, cyc);
    end
  end

  // stimulus: raw-high intervals, cycle numbers relative to reset release
  int st[$];
  int ln[$];

  function automatic bit hi(input int rc);
    foreach (st[i]) if (rc >= st[i] && rc < st[i] + ln[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pin(input int tid, input int rc);
    case (tid)
      1: begin
        if (rc == 12) chk("t1.locked@12", d1_locked, 0);
        if (rc == 13) chk("t1.locked@13", d1_locked, 1);
        if (rc == 43) chk("t1.valid@43",  d1_valid, 0);
        if (rc == 44) begin chk("t1.valid@44", d1_valid, 1); chk("t1.data@44", d1_data, 2); end
        if (rc == 45) chk("t1.valid@45",  d1_valid, 0);
      end
      2: begin
        if (rc == 44) begin chk("t2.valid@44", d1_valid, 1); chk("t2.data@44", d1_data, 0); end
        if (rc == 60) begin chk("t2.valid@60", d1_valid, 1); chk("t2.data@60", d1_data, 3); end
        if (rc == 76) begin chk("t2.valid@76", d1_valid, 1); chk("t2.data@76", d1_data, 1); end
        if (rc == 92) begin chk("t2.valid@92", d1_valid, 1); chk("t2.data@92", d1_data, 2); end
      end
      3: begin
        if (rc == 44) begin chk("t3.err@44", d1_err, 1); chk("t3.valid@44", d1_valid, 0); end
        if (rc == 60) begin chk("t3.valid@60", d1_valid, 1); chk("t3.data@60", d1_data, 2); end
      end
      4: begin
        if (rc == 13) chk("t4.d2locked@13", d2_locked, 0);
        if (rc == 14) chk("t4.d2locked@14", d2_locked, 1);
        if (rc == 44) chk("t4.d1err@44",    d1_err, 1);
        if (rc == 45) begin chk("t4.d2valid@45", d2_valid, 1); chk("t4.d2data@45", d2_data, 3); end
      end
      5: begin
        if (rc == 59)  chk("t5.locked@59",  d1_locked, 1);
        if (rc == 60)  chk("t5.locked@60",  d1_locked, 0);
        if (rc == 61)  chk("t5.locked@61",  d1_locked, 0);
        if (rc == 73)  chk("t5.locked@73",  d1_locked, 1);
        if (rc == 88)  chk("t5.valid@88",   d1_valid, 0);
        if (rc == 104) begin chk("t5.valid@104", d1_valid, 1); chk("t5.data@104", d1_data, 1); end
      end
      6: begin
        if (rc == 32) chk("t6.locked@32", d1_locked, 1);
      end
      default: ;
    endcase
  endtask

  task automatic run_test(input int tid, input int dur, input int rst_at);
    pulse_in = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int rc = 0; rc < dur; rc++) begin
      pulse_in = hi(rc);
      if (rc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst.locked", d1_locked, 0);
        chk("rst.valid",  d1_valid, 0);
        chk("rst.data",   d1_data, 0);
        break;
      end
      pin(tid, rc);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.locked", d1_locked, 0);
    chk("reset.valid",  d1_valid, 0);
    chk("reset.err",    d1_err, 0);
    chk("reset.data",   d1_data, 0);

    st = '{10, 34};         ln = '{1, 1};
    run_test(1, 70, -1);
    st = '{10, 26, 54, 62, 82}; ln = '{1, 1, 1, 1, 1};
    run_test(2, 110, -1);
    st = '{10, 26, 30, 50}; ln = '{1, 1, 1, 1};
    run_test(3, 70, -1);
    st = '{10, 33, 38};     ln = '{2, 1, 2};
    run_test(4, 70, -1);
    st = '{10, 58, 70, 90}; ln = '{1, 1, 1, 1};
    run_test(5, 120, -1);
    st = '{10, 30};         ln = '{1, 1};
    run_test(6, 60, 33);
    st = '{10, 34};         ln = '{1, 1};
    run_test(1, 70, -1);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
